// File: rtl/pcm_dc_remover_pkg.sv
// Shared width helpers for the PCM DC remover.
package pcm_dc_remover_pkg;

    // The extra bit above SW+SHIFT leaves headroom for a full-scale input step.
    function automatic int dcrm_acc_width(input int sw, input int shift);
        return sw + shift + 1;
    endfunction

endpackage

// File: rtl/pcm_dcrm_sat.sv
// Signed saturator from SW+1 bits down to SW bits, with an overflow flag.
// Compiled only when DCRM_SAT_EN is defined; the wrapping build does not use it.
`ifdef DCRM_SAT_EN
module pcm_dcrm_sat #(
    parameter int SW = 8
) (
    input  logic signed [SW:0]   din,
    output logic signed [SW-1:0] dout,
    output logic                 ovf
);

    always_comb begin
        ovf = din[SW] ^ din[SW-1];
        if (!ovf)
            dout = din[SW-1:0];
        else if (din[SW])
            dout = {1'b1, {(SW-1){1'b0}}};
        else
            dout = {1'b0, {(SW-1){1'b1}}};
    end

endmodule
`endif

// File: rtl/pcm_dc_remover.sv
// Leaky-integrator DC remover for 8-bit PCM feeding the mixer.
// Define DCRM_SAT_EN for a saturating output with a clip flag; otherwise dout wraps.
module pcm_dc_remover
    import pcm_dc_remover_pkg::*;
#(
    parameter int SW        = 8,
    parameter int SHIFT     = 8,
    parameter int SIGNED_IN = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample,
    input  logic [SW-1:0] din,
    output logic [SW-1:0] dout,
    output logic [SW-1:0] dc,
    output logic          clip
);

    localparam int AW = dcrm_acc_width(SW, SHIFT);

    logic signed [SW-1:0] din_s;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_shr;
    logic signed [AW-1:0] acc_nxt;
    logic signed [SW-1:0] dc_s;
    logic signed [SW:0]   diff;
    logic        [SW-1:0] dout_nxt;

    always_comb begin
        if (SIGNED_IN != 0)
            din_s = din;
        else
            din_s = {~din[SW-1], din[SW-2:0]};
    end

    // Floor shift, so a constant input settles with dc equal to the input exactly.
    assign acc_shr = acc >>> SHIFT;
    assign dc_s    = acc_shr[SW-1:0];
    assign dc      = dc_s;
    assign diff    = {din_s[SW-1], din_s} - {dc_s[SW-1], dc_s};
    assign acc_nxt = acc + {{(AW-SW){din_s[SW-1]}}, din_s} - acc_shr;

`ifdef DCRM_SAT_EN
    logic sat_ovf;

    pcm_dcrm_sat #(
        .SW   (SW)
    ) u_sat (
        .din  (diff),
        .dout (dout_nxt),
        .ovf  (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clip <= 1'b0;
        else if (sample)
            clip <= sat_ovf;
    end
`else
    logic diff_msb_unused;

    assign diff_msb_unused = diff[SW];
    assign dout_nxt        = diff[SW-1:0];
    assign clip            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            dout <= '0;
        end else if (sample) begin
            acc  <= acc_nxt;
            dout <= dout_nxt;
        end
    end

endmodule

// File: tb/tb_pcm_dc_remover.sv
// Randomized self-checking bench for pcm_dc_remover against an integer reference model.
// Expected saturation behaviour follows DCRM_SAT_EN, as in the design.
module tb_pcm_dc_remover;

    localparam int SW    = 8;
    localparam int SHIFT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic [7:0] dc;
    logic       clip;

    int tests_run = 0;
    int tests_failed = 0;

    longint m_acc = 0;
    longint m_dout = 0;
    longint m_clip = 0;

    pcm_dc_remover #(
        .SW        (SW),
        .SHIFT     (SHIFT),
        .SIGNED_IN (0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (sample),
        .din    (din),
        .dout   (dout),
        .dc     (dc),
        .clip   (clip)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0)
            q = q - 1;
        return q;
    endfunction

    function automatic longint wrap_sw(input longint v);
        longint m;
        m = ((v % 256) + 256) % 256;
        if (m >= 128)
            m = m - 256;
        return m;
    endfunction

    function automatic longint model_dc();
        return wrap_sw(floor_div(m_acc, 64'sd1 << SHIFT));
    endfunction

    // Offset-binary sample value is simply the code minus mid-scale.
    task automatic model_step(input logic [7:0] d);
        longint x, diff, est;
        x    = longint'(d) - 128;
        est  = floor_div(m_acc, 64'sd1 << SHIFT);
        diff = x - wrap_sw(est);
`ifdef DCRM_SAT_EN
        if (diff > 127) begin
            m_dout = 127;
            m_clip = 1;
        end else if (diff < -128) begin
            m_dout = -128;
            m_clip = 1;
        end else begin
            m_dout = diff;
            m_clip = 0;
        end
`else
        m_dout = wrap_sw(diff);
        m_clip = 0;
`endif
        m_acc = m_acc + x - est;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"}, 32'($signed(dout)), 32'(m_dout));
        check({tag, ".dc"},   32'($signed(dc)),   32'(model_dc()));
        check({tag, ".clip"}, {31'd0, clip},      32'(m_clip));
    endtask

    task automatic step(input string tag, input logic [7:0] d, input logic s);
        @(negedge clk);
        din    = d;
        sample = s;
        @(posedge clk);
        if (s)
            model_step(d);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_acc  = 0;
        m_dout = 0;
        m_clip = 0;
    endtask

    logic signed [7:0] prev_dout;
    logic [7:0]        hold_dout, hold_dc;
    logic              hold_clip;
    logic              mono_ok;

    initial begin
        // Reset held: strobes must not move anything.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din    = 8'h5A;
            sample = ~sample;
            @(posedge clk);
            #1;
            check("rst.dout", 32'($signed(dout)), 0);
            check("rst.dc",   32'($signed(dc)),   0);
            check("rst.clip", {31'd0, clip},      0);
        end
        @(negedge clk);
        sample = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        step("first", 8'h80, 1'b1);
        check("first.silence", 32'($signed(dout)), 0);

        // Silence for a long run.
        for (int i = 0; i < 4096; i++)
            step("silence", 8'h80, 1'b1);
        check("silence.end_dc", 32'($signed(dc)), 0);

        // Step to +64 and let it settle.
        step("step_first", 8'hC0, 1'b1);
        check("step.first_dout", 32'($signed(dout)), 64);
        prev_dout = $signed(dout);
        mono_ok   = 1'b1;
        for (int i = 1; i < 2048; i++) begin
            step("step", 8'hC0, 1'b1);
            if ($signed(dout) > prev_dout)
                mono_ok = 1'b0;
            prev_dout = $signed(dout);
        end
        check("step.monotonic", {31'd0, mono_ok}, 1);
        check("step.settled_dout", 32'($signed(dout)), 0);
        check("step.settled_dc",   32'($signed(dc)),   64);

        // Mid-stream asynchronous reset, released before the next edge.
        for (int i = 0; i < 20; i++)
            step("pre_arst", 8'hC0, 1'b1);
        @(negedge clk);
        sample = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.dout", 32'($signed(dout)), 0);
        check("arst.dc",   32'($signed(dc)),   0);
        check("arst.clip", {31'd0, clip},      0);
        model_reset();
        #1;
        rst_n = 1'b1;
        step("post_arst", 8'hC0, 1'b1);
        check("arst.restart_dout", 32'($signed(dout)), 64);

        // Settle at full negative scale, then jump to full positive.
        for (int i = 0; i < 2048; i++)
            step("neg_settle", 8'h00, 1'b1);
        check("neg.dc", 32'($signed(dc)), -128);
        step("overflow", 8'hFF, 1'b1);
`ifdef DCRM_SAT_EN
        check("ovf.dout", 32'($signed(dout)), 127);
        check("ovf.clip", {31'd0, clip},      1);
`else
        check("ovf.dout", 32'($signed(dout)), -1);
        check("ovf.clip", {31'd0, clip},      0);
`endif
        for (int i = 0; i < 20; i++)
            step("clip_hold", 8'($urandom_range(255)), 1'b0);

        // Strobe gap: outputs frozen while din wanders.
        for (int i = 0; i < 10; i++)
            step("pre_gap", 8'hC0, 1'b1);
        hold_dout = dout;
        hold_dc   = dc;
        hold_clip = clip;
        for (int i = 0; i < 100; i++) begin
            step("gap", 8'($urandom_range(255)), 1'b0);
            if (i % 25 == 24) begin
                check("gap.dout", {24'd0, dout}, {24'd0, hold_dout});
                check("gap.dc",   {24'd0, dc},   {24'd0, hold_dc});
                check("gap.clip", {31'd0, clip}, {31'd0, hold_clip});
            end
        end

        // Random stream with random strobe pattern, including back-to-back strobes.
        for (int i = 0; i < 1500; i++)
            step("rand", 8'($urandom_range(255)), ($urandom_range(3) != 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
